// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM state encodings,
// access opcodes, counter width and the default geometry/timing values.
package mem_pkg;

  // Responder FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  // Latched operation codes
  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  // Default parameter values
  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_WAIT_CYC = 2;

  // Wait counter width; covers WAIT_CYC 0..15
  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_array_sync.sv
// Single-port synchronous word array: write enable, registered read,
// no reset on either the storage or the read register.
module mem_array_sync #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write port and registered read port share the single address
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/memory_responder.sv
// Memory responder: accepts one read or write request at a time, inserts
// WAIT_CYC wait states, commits the access and pulses MEM_ack.
// Optional feature: define MEM_RANGE_CHECK_EN to flag accesses whose
// address has non-zero bits above ADDR_W (ERR with the ack, no access).
// WAIT_CYC must lie in 0..15.
module memory_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int WAIT_CYC = DEF_WAIT_CYC
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic [15:0] MAR_in,
  input  logic [15:0] M_bus_in,
  input  logic        RD_req,
  input  logic        WR_req,
  output logic [15:0] M_bus_out,
  output logic        MEM_busy,
  output logic        MEM_ack,
  output logic        ERR
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYC);

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [15:0]       data_reg;
  logic              op_reg;
  logic              range_err_reg;
  logic              busy_reg;
  logic              ack_reg;
  logic              err_reg;
  logic              rd_valid_reg;

  logic              req;
  logic              req_op;
  logic              in_range_err;
  logic              start;
  logic              commit;
  logic [ADDR_W-1:0] c_addr;
  logic [15:0]       c_data;
  logic              c_op;
  logic              c_err;
  logic              arr_we;
  logic              arr_re;
  logic [15:0]       arr_rdata;

  assign req    = RD_req | WR_req;
  // Write wins over a simultaneous read
  assign req_op = WR_req ? OP_WR : OP_RD;

`ifdef MEM_RANGE_CHECK_EN
  // Any address bit above the array index makes the access illegal
  assign in_range_err = ((MAR_in >> ADDR_W) != 16'h0000);
`else
  // Upper address bits alias away; they are deliberately not used
  logic unused_upper_addr;
  assign unused_upper_addr = |(MAR_in >> ADDR_W);
  assign in_range_err      = 1'b0;
`endif

  assign start = (state_reg == ST_IDLE) && req;

  // With zero wait states the access commits on the sampling edge itself,
  // so the commit path takes the live inputs instead of the latches.
  assign commit = (start && (WAIT_CYC == 0)) ||
                  ((state_reg == ST_WAIT) && (cnt_reg == CNT_W'(1)));

  // Select live inputs in IDLE, latched values otherwise
  always_comb begin
    c_addr = addr_reg;
    c_data = data_reg;
    c_op   = op_reg;
    c_err  = range_err_reg;
    if (state_reg == ST_IDLE) begin
      c_addr = MAR_in[ADDR_W-1:0];
      c_data = M_bus_in;
      c_op   = req_op;
      c_err  = in_range_err;
    end
  end

  // Array strobes are suppressed while reset is held so an edge during
  // reset can never corrupt the contents.
  assign arr_we = commit && (c_op == OP_WR) && !c_err && CLR;
  assign arr_re = commit && (c_op == OP_RD) && !c_err && CLR;

  mem_array_sync #(
    .ADDR_W (ADDR_W),
    .DATA_W (16)
  ) u_array (
    .clk   (CLK),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (c_addr),
    .wdata (c_data),
    .rdata (arr_rdata)
  );

  // Responder FSM with wait counter, request latches and registered flags.
  // The counter is loaded with WAIT_CYC and the access commits on the edge
  // where it steps to zero, giving WAIT_CYC cycles spent in WAIT.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      addr_reg      <= '0;
      data_reg      <= '0;
      op_reg        <= OP_RD;
      range_err_reg <= 1'b0;
      busy_reg      <= 1'b0;
      ack_reg       <= 1'b0;
      err_reg       <= 1'b0;
      rd_valid_reg  <= 1'b0;
    end else begin
      if (arr_re) begin
        rd_valid_reg <= 1'b1;
      end
      case (state_reg)
        ST_IDLE: begin
          ack_reg <= 1'b0;
          err_reg <= 1'b0;
          if (req) begin
            addr_reg      <= MAR_in[ADDR_W-1:0];
            data_reg      <= M_bus_in;
            op_reg        <= req_op;
            range_err_reg <= in_range_err;
            cnt_reg       <= WAIT_INIT;
            busy_reg      <= 1'b1;
            if (WAIT_CYC == 0) begin
              state_reg <= ST_ACK;
              ack_reg   <= 1'b1;
              err_reg   <= in_range_err;
            end else begin
              state_reg <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          cnt_reg <= cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) begin
            state_reg <= ST_ACK;
            ack_reg   <= 1'b1;
            err_reg   <= range_err_reg;
          end
        end
        ST_ACK: begin
          state_reg <= ST_IDLE;
          ack_reg   <= 1'b0;
          err_reg   <= 1'b0;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
          ack_reg   <= 1'b0;
          err_reg   <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // The array read register holds its value between reads; it is shown
  // only once a read has committed since reset, otherwise zero.
  assign M_bus_out = rd_valid_reg ? arr_rdata : 16'h0000;
  assign MEM_busy  = busy_reg;
  assign MEM_ack   = ack_reg;
  assign ERR       = err_reg;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: a WAIT_CYC=2 instance for most
// scenarios and a WAIT_CYC=0 instance for zero-wait back-to-back accesses.
module tb_memory_responder;

  logic        CLK;
  logic        CLR;
  logic [15:0] MAR_in, M_bus_in, M_bus_out;
  logic        RD_req, WR_req, MEM_busy, MEM_ack, ERR;
  logic [15:0] mar_z, mbin_z, mbout_z;
  logic        rd_z, wr_z, busy_z, ack_z, err_z;

  int errors = 0;
  int checks = 0;
  logic [15:0] last_rd_exp;

  memory_responder #(.ADDR_W(8), .WAIT_CYC(2)) dut (
    .CLK(CLK), .CLR(CLR), .MAR_in(MAR_in), .M_bus_in(M_bus_in),
    .RD_req(RD_req), .WR_req(WR_req), .M_bus_out(M_bus_out),
    .MEM_busy(MEM_busy), .MEM_ack(MEM_ack), .ERR(ERR)
  );

  memory_responder #(.ADDR_W(8), .WAIT_CYC(0)) dut_z (
    .CLK(CLK), .CLR(CLR), .MAR_in(mar_z), .M_bus_in(mbin_z),
    .RD_req(rd_z), .WR_req(wr_z), .M_bus_out(mbout_z),
    .MEM_busy(busy_z), .MEM_ack(ack_z), .ERR(err_z)
  );

  always #5 CLK = ~CLK;

  // Issues one request on the WAIT_CYC=2 instance and measures it; lat is
  // the number of edges from the sampling edge (1) to the ack cycle.
  task automatic run_access(input logic rd, input logic wr,
                            input logic [15:0] addr, input logic [15:0] data,
                            output int lat, output int busy_cnt,
                            output logic [15:0] dout, output logic err_seen);
    RD_req = rd; WR_req = wr; MAR_in = addr; M_bus_in = data;
    lat = -1; busy_cnt = 0; dout = 16'h0; err_seen = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge CLK); #1;
      RD_req = 1'b0; WR_req = 1'b0;
      if (MEM_busy) busy_cnt++;
      if (MEM_ack) begin
        lat = i; dout = M_bus_out; err_seen = ERR;
        break;
      end
    end
    @(posedge CLK); #1;
    $display("access rd=%0b wr=%0b addr=%h data=%h lat=%0d busy=%0d dout=%h err=%0b",
             rd, wr, addr, data, lat, busy_cnt, dout, err_seen);
  endtask

  task automatic test_reset();
    checks++; if (M_bus_out !== 16'h0000) begin errors++; $display("FAIL reset_mbus: got %h expected 0000", M_bus_out); end
    checks++; if (MEM_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", MEM_busy); end
    checks++; if (MEM_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", MEM_ack); end
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", ERR); end
    checks++; if (mbout_z !== 16'h0000) begin errors++; $display("FAIL reset_mbus_z: got %h expected 0000", mbout_z); end
    checks++; if (busy_z !== 1'b0) begin errors++; $display("FAIL reset_busy_z: got %b expected 0", busy_z); end
    $display("reset checked");
  endtask

  task automatic test_write_read();
    int lat, bc; logic [15:0] d; logic e;
    run_access(1'b0, 1'b1, 16'h0012, 16'hBEEF, lat, bc, d, e);
    checks++; if (lat !== 3) begin errors++; $display("FAIL wr_latency: got %0d expected 3", lat); end
    checks++; if (bc !== 3) begin errors++; $display("FAIL wr_busy_cycles: got %0d expected 3", bc); end
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL wr_mbus_unchanged: got %h expected 0000", d); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL wr_err: got %b expected 0", e); end
    run_access(1'b1, 1'b0, 16'h0012, 16'h0000, lat, bc, d, e);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rd_latency: got %0d expected 3", lat); end
    checks++; if (bc !== 3) begin errors++; $display("FAIL rd_busy_cycles: got %0d expected 3", bc); end
    checks++; if (d !== 16'hBEEF) begin errors++; $display("FAIL rd_data: got %h expected BEEF", d); end
    checks++; if (MEM_busy !== 1'b0) begin errors++; $display("FAIL rd_idle_busy: got %b expected 0", MEM_busy); end
    last_rd_exp = 16'hBEEF;
  endtask

  task automatic test_wait0_back_to_back();
    logic exp_ack;
    wr_z = 1'b1; mar_z = 16'h0040; mbin_z = 16'h7777;
    @(posedge CLK); #1;
    wr_z = 1'b0;
    checks++; if (ack_z !== 1'b1) begin errors++; $display("FAIL z_wr_ack_n1: got %b expected 1", ack_z); end
    @(posedge CLK); #1;
    checks++; if (ack_z !== 1'b0) begin errors++; $display("FAIL z_ack_drop: got %b expected 0", ack_z); end
    rd_z = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      exp_ack = (i % 2 == 0);
      $display("z cycle %0d ack=%b mbus=%h", i, ack_z, mbout_z);
      checks++; if (ack_z !== exp_ack) begin errors++; $display("FAIL z_b2b_ack[%0d]: got %b expected %b", i, ack_z, exp_ack); end
      if (i == 0 || i == 4) begin
        checks++; if (mbout_z !== 16'h7777) begin errors++; $display("FAIL z_rd_data[%0d]: got %h expected 7777", i, mbout_z); end
      end
    end
    rd_z = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_simultaneous();
    int lat, bc; logic [15:0] d; logic e;
    run_access(1'b1, 1'b1, 16'h0005, 16'h1234, lat, bc, d, e);
    checks++; if (lat !== 3) begin errors++; $display("FAIL sim_latency: got %0d expected 3", lat); end
    checks++; if (d !== 16'hBEEF) begin errors++; $display("FAIL sim_mbus_unchanged: got %h expected BEEF", d); end
    run_access(1'b1, 1'b0, 16'h0005, 16'h0000, lat, bc, d, e);
    checks++; if (d !== 16'h1234) begin errors++; $display("FAIL sim_readback: got %h expected 1234", d); end
    last_rd_exp = 16'h1234;
  endtask

  task automatic test_reset_abort();
    int lat, bc, acks; logic [15:0] d; logic e;
    run_access(1'b0, 1'b1, 16'h0007, 16'h5555, lat, bc, d, e);
    WR_req = 1'b1; MAR_in = 16'h0007; M_bus_in = 16'hAAAA;
    @(posedge CLK); #1;
    WR_req = 1'b0;
    checks++; if (MEM_busy !== 1'b1) begin errors++; $display("FAIL abort_in_wait: got %b expected 1", MEM_busy); end
    #2 CLR = 1'b0;
    #1;
    checks++; if (M_bus_out !== 16'h0000) begin errors++; $display("FAIL abort_mbus: got %h expected 0000", M_bus_out); end
    checks++; if (MEM_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", MEM_busy); end
    checks++; if (MEM_ack !== 1'b0) begin errors++; $display("FAIL abort_ack: got %b expected 0", MEM_ack); end
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL abort_err: got %b expected 0", ERR); end
    @(posedge CLK); #1;
    CLR = 1'b1;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      if (MEM_ack) acks++;
    end
    checks++; if (acks !== 0) begin errors++; $display("FAIL abort_no_ack: got %0d expected 0", acks); end
    run_access(1'b1, 1'b0, 16'h0007, 16'h0000, lat, bc, d, e);
    checks++; if (d !== 16'h5555) begin errors++; $display("FAIL abort_old_data: got %h expected 5555", d); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL abort_rd_latency: got %0d expected 3", lat); end
    last_rd_exp = 16'h5555;
  endtask

  task automatic test_range();
    int lat, bc; logic [15:0] d; logic e;
    logic exp_err; logic [15:0] exp_word;
`ifdef MEM_RANGE_CHECK_EN
    exp_err = 1'b1; exp_word = 16'hCAFE;
`else
    exp_err = 1'b0; exp_word = 16'h0BAD;
`endif
    run_access(1'b0, 1'b1, 16'h0000, 16'hCAFE, lat, bc, d, e);
    run_access(1'b0, 1'b1, 16'h0100, 16'h0BAD, lat, bc, d, e);
    checks++; if (e !== exp_err) begin errors++; $display("FAIL range_err: got %b expected %b", e, exp_err); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL range_latency: got %0d expected 3", lat); end
    run_access(1'b1, 1'b0, 16'h0000, 16'h0000, lat, bc, d, e);
    checks++; if (d !== exp_word) begin errors++; $display("FAIL range_word0: got %h expected %h", d, exp_word); end
    last_rd_exp = exp_word;
  endtask

  task automatic test_busy_ignore();
    int lat, bc, acks; logic [15:0] d; logic e;
    WR_req = 1'b1; MAR_in = 16'h0020; M_bus_in = 16'h1111;
    @(posedge CLK); #1;
    WR_req = 1'b0; RD_req = 1'b1; MAR_in = 16'h0012;
    @(posedge CLK); #1;
    RD_req = 1'b0;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK); #1;
      if (MEM_ack) acks++;
    end
    $display("busy_ignore acks=%0d mbus=%h", acks, M_bus_out);
    checks++; if (acks !== 1) begin errors++; $display("FAIL busy_one_ack: got %0d expected 1", acks); end
    checks++; if (M_bus_out !== last_rd_exp) begin errors++; $display("FAIL busy_mbus_held: got %h expected %h", M_bus_out, last_rd_exp); end
    run_access(1'b1, 1'b0, 16'h0020, 16'h0000, lat, bc, d, e);
    checks++; if (d !== 16'h1111) begin errors++; $display("FAIL busy_write_done: got %h expected 1111", d); end
  endtask

  initial begin
    CLK = 1'b0; CLR = 1'b0;
    MAR_in = 16'h0; M_bus_in = 16'h0; RD_req = 1'b0; WR_req = 1'b0;
    mar_z = 16'h0; mbin_z = 16'h0; rd_z = 1'b0; wr_z = 1'b0;
    last_rd_exp = 16'h0000;
    #2;
    test_reset();
    @(posedge CLK); #1;
    CLR = 1'b1;
    @(posedge CLK); #1;
    test_write_read();
    test_wait0_back_to_back();
    test_simultaneous();
    test_reset_abort();
    test_range();
    test_busy_ignore();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 Parameter ADDR_W, default 8, meaning: number of low MAR bits that index the word array (2^ADDR_W 16-bit words).
REQ-002 Parameter WAIT_CYC, default 2, meaning: wait states inserted before each access commits; legal range 0..15.
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 CLR  input  1  reset, asynchronous, active-low.
REQ-005 MAR_in  input  16  access address, driven by the datapath MAR output.
REQ-006 M_bus_in  input  16  write data, driven by the datapath MDR-to-M-bus output.
REQ-007 RD_req  input  1  read request, sampled only in IDLE.
REQ-008 WR_req  input  1  write request, sampled only in IDLE.
REQ-009 M_bus_out  output  16  read data returned to the datapath MDR (M-bus side).
REQ-010 MEM_busy  output  1  high while a request is in progress (WAIT and ACK states).
REQ-011 MEM_ack  output  1  one-cycle completion pulse.
REQ-012 ERR  output  1  access-error flag, valid only in the MEM_ack cycle.

Function
REQ-013 FSM states: IDLE, WAIT, ACK.
REQ-014 IDLE with RD_req or WR_req high at a clock edge: latch MAR_in, M_bus_in and the operation; load the wait counter with WAIT_CYC; go to WAIT, or go straight to ACK when WAIT_CYC = 0.
REQ-015 Simultaneous RD_req and WR_req: write wins; the read is dropped without any indication.
REQ-016 WAIT: decrement the counter each cycle; when the counter reads 0, commit the access and go to ACK.
REQ-017 Commit for a write: store the latched data at the latched address.
REQ-018 Commit for a read: register the array word into M_bus_out.
REQ-019 ACK: MEM_ack = 1 for exactly one cycle, then go to IDLE.
REQ-020 Latency is WAIT_CYC+1 cycles from the sampling edge to the MEM_ack cycle, and M_bus_out is valid in the MEM_ack cycle.
REQ-021 M_bus_out holds the last read value until the next read commit; writes never alter it.
REQ-022 RD_req and WR_req are ignored while MEM_busy = 1; no queuing.
REQ-023 A request held high continuously starts a new access on the edge after ACK, i.e. one access every WAIT_CYC+2 cycles.
REQ-024 Array index = MAR_in[ADDR_W-1:0]; index arithmetic is unsigned with no carry into higher bits.
REQ-025 A read-after-write to the same address returns the newly written data.

Reset
REQ-026 While CLR = 0: state = IDLE, counter = 0, M_bus_out = 0x0000, MEM_busy = 0, MEM_ack = 0, ERR = 0.
REQ-027 Reset asserted mid-operation aborts the access; an uncommitted write is discarded.
REQ-028 Array contents are not cleared by reset.

Configuration
REQ-029 With macro MEM_RANGE_CHECK_EN defined: if any of MAR_in[15:ADDR_W] is non-zero at latch, the access does not touch the array or M_bus_out, and ERR = 1 with the MEM_ack pulse; latency is unchanged.
REQ-030 Without MEM_RANGE_CHECK_EN: the upper address bits are ignored (addresses alias modulo 2^ADDR_W) and ERR is tied to 0.

Structure
REQ-031 A shared package/include mem_pkg holds the FSM state encodings, the opcode constants (OP_RD, OP_WR) and the default ADDR_W/WAIT_CYC values.
REQ-032 One sub-module, mem_array_sync, provides the 16-bit single-port synchronous array: write enable, registered read, no reset.
REQ-033 The FSM, wait counter, latches and range check reside in memory_responder.

Verification
REQ-034 Write then read, WAIT_CYC = 2: write 0xBEEF at MAR 0x0012 (MEM_ack 3 cycles after the request), then read 0x0012 -> M_bus_out = 0xBEEF in the MEM_ack cycle; MEM_busy high for 3 cycles per access.
REQ-035 WAIT_CYC = 0: read request at cycle n -> MEM_ack at cycle n+1; a request held high gives back-to-back acks every 2 cycles.
REQ-036 Simultaneous RD_req and WR_req with data 0x1234 at 0x0005 -> write performed, M_bus_out unchanged; a later read of 0x0005 returns 0x1234.
REQ-037 Reset pulsed in WAIT during a write of 0xAAAA to 0x0007 (prior value 0x5555) -> all outputs go to 0 asynchronously, no ack, and a later read returns 0x5555.
REQ-038 MEM_RANGE_CHECK_EN, ADDR_W = 8: write to 0x0100 -> ERR = 1 with ack and address 0x0000 unchanged; without the macro, the same write lands at 0x0000 and ERR = 0.
REQ-039 Request pulsed while MEM_busy = 1 -> ignored; exactly one ack observed.
